// File: rtl/imm_decode_stage.sv
// RISC-V immediate/format decoder registered behind a valid/ready stage with a
// 2-entry skid buffer (main drives the outputs, skid absorbs one stall cycle).
module imm_decode_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_count
);
    localparam int unsigned INST_W = 32;
    localparam int unsigned FMT_W  = 3;

    typedef enum logic [FMT_W-1:0] {
        FMT_NONE    = 3'd0,
        FMT_I       = 3'd1,
        FMT_SHIFT   = 3'd2,
        FMT_S       = 3'd3,
        FMT_B       = 3'd4,
        FMT_J       = 3'd5,
        FMT_U       = 3'd6,
        FMT_UNKNOWN = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [XLEN-1:0]   imm;
        fmt_e              fmt;
        logic              illegal;
    } entry_t;

    entry_t           dec;
    entry_t           main_q;
    entry_t           skid_q;
    logic             main_valid;
    logic             skid_valid;
    logic [CNT_W-1:0] cnt_q;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [5:0]       shamt;
    logic             accept;
    logic             pop;

    // Combinational decode of the incoming word
    always_comb begin
        opcode      = in_inst[6:0];
        funct3      = in_inst[14:12];
        shamt       = (XLEN == 64) ? in_inst[25:20] : {1'b0, in_inst[24:20]};
        dec         = '0;
        dec.inst    = in_inst;
        dec.fmt     = FMT_UNKNOWN;
        dec.illegal = 1'b0;
        case (opcode)
            7'b0000011, 7'b1100111: begin
                dec.fmt = FMT_I;
                dec.imm = XLEN'($signed(in_inst[31:20]));
            end
            7'b0010011: begin
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec.fmt = FMT_SHIFT;
                    dec.imm = XLEN'(shamt);
                end else begin
                    dec.fmt = FMT_I;
                    dec.imm = XLEN'($signed(in_inst[31:20]));
                end
            end
            7'b0100011: begin
                dec.fmt = FMT_S;
                dec.imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
            end
            7'b1100011: begin
                dec.fmt = FMT_B;
                dec.imm = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                         in_inst[11:8], 1'b0}));
            end
            7'b1101111: begin
                dec.fmt = FMT_J;
                dec.imm = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                         in_inst[30:21], 1'b0}));
            end
            7'b0110111, 7'b0010111: begin
                dec.fmt = FMT_U;
                dec.imm = XLEN'($signed({in_inst[31:12], 12'b0}));
            end
            7'b0110011: begin
                dec.fmt = FMT_NONE;
            end
            default: begin
                dec.fmt     = FMT_UNKNOWN;
                dec.illegal = 1'b1;
            end
        endcase
    end

    assign in_ready = ~skid_valid;
    assign accept   = in_valid & in_ready & ~flush;
    assign pop      = main_valid & out_ready;

    // Buffer update: flush wins; otherwise refill main from skid or input in order
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (pop || !main_valid) begin
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= accept;
                if (accept) begin
                    skid_q <= dec;
                end
            end else begin
                main_valid <= accept;
                if (accept) begin
                    main_q <= dec;
                end
            end
        end else if (accept) begin
            skid_q     <= dec;
            skid_valid <= 1'b1;
        end
    end

    // Saturating count of accepted unknown opcodes; survives flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (accept && dec.illegal && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign out_valid     = main_valid;
    assign out_inst      = main_q.inst;
    assign out_imm       = main_q.imm;
    assign out_fmt       = main_q.fmt;
    assign out_illegal   = main_q.illegal;
    assign illegal_count = cnt_q;

endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

Registered, parametrised successor to the combinational immediate generator: decodes the immediate and instruction format of an incoming 32-bit RISC-V instruction and presents it one cycle later through a valid/ready pipeline stage with a 2-entry skid buffer. It sits between fetch and the execute-operand mux. It generalises output width to RV32/RV64, classifies the format explicitly, flags and counts unknown opcodes, and supports pipeline flush.

## Interface
- XLEN, 32: immediate width; legal values 32 or 64.
- CNT_W, 16: width of the saturating illegal-opcode counter.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous and active-low.
- flush  in  1  synchronous discard of all buffered entries.
- in_valid  in  1  instruction presented.
- in_ready  out  1  stage can accept this cycle.
- in_inst  in  32  instruction word.
- out_valid  out  1  decoded entry available.
- out_ready  in  1  consumer accepts entry.
- out_inst  out  32  instruction of the head entry, passed through unchanged.
- out_imm  out  XLEN  sign/zero-extended immediate.
- out_fmt  out  3  0 NONE (R-type), 1 I, 2 SHIFT, 3 S, 4 B, 5 J, 6 U, 7 UNKNOWN.
- out_illegal  out  1  head entry's opcode is not decoded (out_fmt = 7).
- illegal_count  out  CNT_W  number of accepted UNKNOWN instructions, saturating.

## Operation
- Decode is combinational on in_inst. The result {inst, imm, fmt, illegal} is stored at acceptance.
- Opcode 0000011 / 1100111 / 0010011 (funct3 ∉ {001,101}) → I: sign-extend inst[31:20].
- Opcode 0010011, funct3 001/101 → SHIFT: zero-extend shamt. shamt is inst[24:20] for XLEN=32 and inst[25:20] for XLEN=64. funct7 bits are excluded.
- Opcode 0100011 → S: sign-extend {inst[31:25], inst[11:7]}.
- Opcode 1100011 → B: sign-extend {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
- Opcode 1101111 → J: sign-extend {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
- Opcode 0110111 / 0010111 → U: {inst[31:12], 12'b0}, sign-extended to XLEN.
- Opcode 0110011 → NONE: imm = 0.
- Any other opcode → UNKNOWN: imm = 0, illegal = 1.
- Storage is two entries: main (drives the out_* ports) and skid.
  - in_ready = !skid_valid, taken from a register, so there is no in_valid→in_ready path.
  - Accept (in_valid && in_ready) writes to main if main is empty or is popping this cycle; otherwise it writes to skid.
  - Pop (out_valid && out_ready) with skid_valid moves skid→main. An accept in the same cycle then writes into skid.
  - Entries leave strictly in arrival order.
- illegal_count increments by 1 on each accept of an UNKNOWN instruction. It holds at 2^CNT_W−1. It is not cleared by flush.
- flush: at the next edge both entries are invalidated. A same-cycle in_valid is discarded and not counted. A same-cycle pop still counts as delivered.

## Timing
- Reset values: out_valid=0, out_inst=0, out_imm=0, out_fmt=0, out_illegal=0, illegal_count=0, internal skid_valid=0. in_ready is therefore 1 during and after reset.
- Reset asserted mid-operation empties the buffer immediately (asynchronously). It does not depend on a clock edge.
- Latency: an instruction accepted at edge N appears on out_* right after edge N, provided main was free.
- Throughput: 1 instruction/cycle while out_ready=1.
- Backpressure: with out_ready=0, two instructions are accepted, then in_ready falls on the edge that fills skid. in_ready rises again on the edge after the first pop.
- out_* remain stable while out_valid=1 and out_ready=0.
- flush has priority over accept and pop-refill. After the flush edge, out_valid=0 and in_ready=1.

## Test plan
- Decode sweep, XLEN=32: 0xFFF00093 → imm 0xFFFFFFFF, fmt 1; 0x4030D093 → imm 0x00000003, fmt 2; 0xFE000CE3 → imm 0xFFFFFFF8, fmt 4; 0x123452B7 → imm 0x12345000, fmt 6; 0x002081B3 → imm 0, fmt 0.
- XLEN=64: 0x03F09093 (SLLI, shamt 63) → imm 0x3F; 0x800002B7 → imm 0xFFFFFFFF80000000.
- Backpressure: stream 4 instructions with out_ready=0 → exactly 2 accepted and in_ready=0. Release out_ready → outputs appear in original order, one per cycle, with none lost or duplicated.
- Flush with both entries full and in_valid=1 → next cycle out_valid=0, in_ready=1, and the discarded instruction never appears.
- Illegal counting, CNT_W=4: accept 20 words with opcode 1111111 → out_illegal=1 on each, illegal_count=15. A flush leaves the count at 15.
- Assert rst_n=0 asynchronously mid-stream with out_valid=1 → out_valid drops before the next edge, and all outputs equal their reset values.
